merge3_rr: RTL and testbench

//  Three-to-one stream merger: the inverse of the 3-way demux. It arbitrates

---
 rtl/merge3_rr.sv | 129 ++++++++++++
 tb/tb_merge3_rr.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/merge3_rr.sv
// Three-to-one round-robin stream merger with bounded bursts and a single
// registered output stage; f_sel tags each beat with its source channel.
module merge3_rr #(
  parameter int width = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
  input  logic             c_valid,
  input  logic [width-1:0] c_data,
  output logic             c_ready,
  output logic             f_valid,
  output logic [width-1:0] f_data,
  output logic [1:0]       f_sel,
  input  logic             f_ready
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       last;
  logic [CW-1:0]    burst_cnt;
  logic [CW-1:0]    cnt_inc;
  logic [2:0]       valids;
  logic [2:0]       pick;
  logic [1:0]       grant;
  logic             gvalid;
  logic             owner_valid;
  logic             arb;
  logic             can_load;
  logic             xfer;
  logic [width-1:0] gdata;

  // First valid channel strictly after l in the order a->b->c->a; bit 2 = hit.
  function automatic logic [2:0] rr_pick(input logic [1:0] l, input logic [2:0] v);
    logic [2:0] r;
    int         idx;
    r = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(l) + k) % 3;
      if (!r[2] && v[idx]) r = {1'b1, 2'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    valids   = {c_valid, b_valid, a_valid};
    can_load = !f_valid || f_ready;
    case (owner)
      2'd0:    owner_valid = a_valid;
      2'd1:    owner_valid = b_valid;
      default: owner_valid = c_valid;
    endcase
    // A dropped owner falls back to the IDLE arbitration in the same cycle.
    arb  = (state == IDLE) || !owner_valid;
    pick = rr_pick(last, valids);
    if (arb) begin
      gvalid = pick[2];
      grant  = pick[1:0];
    end else begin
      gvalid = 1'b1;
      grant  = owner;
    end
    case (grant)
      2'd0:    gdata = a_data;
      2'd1:    gdata = b_data;
      default: gdata = c_data;
    endcase
    xfer    = can_load && gvalid;
    cnt_inc = burst_cnt + CW'(1);
    a_ready = rst_n && xfer && (grant == 2'd0);
    b_ready = rst_n && xfer && (grant == 2'd1);
    c_ready = rst_n && xfer && (grant == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd0;
      last      <= 2'd2;
      burst_cnt <= '0;
      f_valid   <= 1'b0;
      f_data    <= '0;
      f_sel     <= 2'd0;
    end else begin
      if (xfer) begin
        f_valid <= 1'b1;
        f_data  <= gdata;
        f_sel   <= grant;
      end else if (f_ready) begin
        f_valid <= 1'b0;
      end

      if (can_load) begin
        if (arb) begin
          if (xfer) begin
            owner <= grant;
            last  <= grant;
            if (BURST == 1) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              state     <= OWN;
              burst_cnt <= CW'(1);
            end
          end else begin
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end else if (cnt_inc == CW'(BURST)) begin
          state     <= IDLE;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_merge3_rr.sv
// Directed table plus reset and randomized scoreboard sequences for merge3_rr.
module tb_merge3_rr;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, c_valid;
  logic [7:0] a_data, b_data, c_data;
  logic       a_ready, b_ready, c_ready;
  logic       f_valid;
  logic [7:0] f_data;
  logic [1:0] f_sel;
  logic       f_ready;

  int nvec = 0;
  int nerr = 0;

  merge3_rr #(.width(8), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .f_valid(f_valid), .f_data(f_data), .f_sel(f_sel), .f_ready(f_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  // v and rdy are ordered {a,b,c}
  typedef struct {
    logic [2:0] v;
    logic [7:0] bd;
    logic       fr;
    logic [2:0] rdy;
    logic       fv;
    logic [1:0] sel;
    logic [7:0] fd;
  } vec_t;

  vec_t tbl[35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] in_seq[3];
  logic [7:0] out_seq[3];
  int         wait_cnt[3];

  task automatic observe_out();
    if (f_valid && f_ready) begin
      chk("rand f_sel_legal", 32'(f_sel != 2'd3), 32'd1);
      if (f_sel != 2'd3) begin
        chk($sformatf("rand order ch%0d", f_sel), 32'(f_data), 32'(out_seq[f_sel]));
        out_seq[f_sel] = out_seq[f_sel] + 8'd1;
      end
    end
  endtask

  initial begin
    logic [2:0] acc;
    logic [2:0] vl;

    for (int i = 0; i < 4; i++)   tbl[i] = '{3'b111, 8'(8'h40 + i), 1'b1, 3'b100, 1'b1, 2'd0, 8'(i)};
    for (int i = 4; i < 8; i++)   tbl[i] = '{3'b111, 8'(8'h40 + i), 1'b1, 3'b010, 1'b1, 2'd1, 8'(8'h40 + i)};
    for (int i = 8; i < 12; i++)  tbl[i] = '{3'b111, 8'(8'h40 + i), 1'b1, 3'b001, 1'b1, 2'd2, 8'(8'h80 + i)};
    tbl[12] = '{3'b111, 8'h4C, 1'b1, 3'b100, 1'b1, 2'd0, 8'h0C};
    for (int i = 13; i < 18; i++) tbl[i] = '{3'b111, 8'(8'h40 + i), 1'b0, 3'b000, 1'b1, 2'd0, 8'h0C};
    tbl[18] = '{3'b111, 8'h52, 1'b1, 3'b100, 1'b1, 2'd0, 8'h12};
    tbl[19] = '{3'b001, 8'h53, 1'b1, 3'b001, 1'b1, 2'd2, 8'h93};
    for (int i = 20; i < 23; i++) tbl[i] = '{3'b101, 8'(8'h40 + i), 1'b1, 3'b001, 1'b1, 2'd2, 8'(8'h80 + i)};
    tbl[23] = '{3'b111, 8'h57, 1'b1, 3'b100, 1'b1, 2'd0, 8'h17};
    for (int i = 24; i < 32; i++) tbl[i] = '{3'b010, 8'(8'h10 + i - 24), 1'b1, 3'b010, 1'b1, 2'd1, 8'(8'h10 + i - 24)};
    tbl[32] = '{3'b000, 8'h60, 1'b1, 3'b000, 1'b0, 2'd1, 8'h17};
    tbl[33] = '{3'b111, 8'h61, 1'b0, 3'b001, 1'b1, 2'd2, 8'hA1};
    tbl[34] = '{3'b111, 8'h62, 1'b0, 3'b000, 1'b1, 2'd2, 8'hA1};

    // Reset held with every channel offering data
    rst_n = 1'b0;
    {a_valid, b_valid, c_valid} = 3'b111;
    a_data = 8'hEE; b_data = 8'hEE; c_data = 8'hEE;
    f_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset f_valid", 32'(f_valid), 32'd0);
    chk("reset readies", 32'({a_ready, b_ready, c_ready}), 32'd0);
    chk("reset f_sel", 32'(f_sel), 32'd0);
    chk("reset f_data", 32'(f_data), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (i > 0) @(negedge clk);
      {a_valid, b_valid, c_valid} = tbl[i].v;
      a_data  = 8'(i);
      b_data  = tbl[i].bd;
      c_data  = 8'(8'h80 + i);
      f_ready = tbl[i].fr;
      #1;
      chk($sformatf("v%0d readies", i), 32'({a_ready, b_ready, c_ready}), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d f_valid", i), 32'(f_valid), 32'(tbl[i].fv));
      chk($sformatf("v%0d f_sel", i), 32'(f_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d f_data", i), 32'(f_data), 32'(tbl[i].fd));
    end

    // Asynchronous reset while a beat is stalled in the output register
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset f_valid", 32'(f_valid), 32'd0);
    chk("midreset f_data", 32'(f_data), 32'd0);
    chk("midreset f_sel", 32'(f_sel), 32'd0);
    chk("midreset readies", 32'({a_ready, b_ready, c_ready}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    {a_valid, b_valid, c_valid} = 3'b000;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      in_seq[k] = 8'd0; out_seq[k] = 8'd0; wait_cnt[k] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      c_valid = ($urandom_range(0, 3) != 0);
      f_ready = ($urandom_range(0, 3) != 0);
      a_data  = in_seq[0];
      b_data  = in_seq[1];
      c_data  = in_seq[2];
      #1;
      chk("rand ready_onehot", 32'($countones({a_ready, b_ready, c_ready}) <= 1), 32'd1);
      observe_out();
      acc = {c_valid && c_ready, b_valid && b_ready, a_valid && a_ready};
      vl  = {c_valid, b_valid, a_valid};
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) in_seq[k] = in_seq[k] + 8'd1;
        if (vl[k] && !acc[k]) begin
          wait_cnt[k] += $countones(acc);
          if (acc != 3'b000)
            chk($sformatf("rand fairness ch%0d", k), 32'(wait_cnt[k] <= 2 * BURST), 32'd1);
        end else begin
          wait_cnt[k] = 0;
        end
      end
    end

    // Drain whatever is still in the output register
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      {a_valid, b_valid, c_valid} = 3'b000;
      f_ready = 1'b1;
      #1;
      observe_out();
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("drain count ch%0d", k), 32'(out_seq[k]), 32'(in_seq[k]));
    chk("drain f_valid", 32'(f_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
